reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_pkg.sv | 6 +
 rtl/reorder_buffer_query_port.sv | 55 +++++
 rtl/reorder_buffer.sv | 164 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared CPU widths, also used by the reservation station.
package reorder_buffer_pkg;
  localparam int XLEN_DEF      = 32;
  localparam int REG_WIDTH     = 5;
  localparam int ROB_WIDTH_DEF = 4;
endpackage

// File: rtl/reorder_buffer_query_port.sv
// One operand lookup into the reorder buffer.
// With ROB_WB_FORWARD_EN defined, a same-cycle writeback to a busy entry is forwarded.
module rob_query_port
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_WIDTH = ROB_WIDTH_DEF,
  parameter int XLEN      = XLEN_DEF
) (
  input  logic [ROB_WIDTH-1:0]    query_tag_i,
  input  logic [2**ROB_WIDTH-1:0] busy_i,
  input  logic [2**ROB_WIDTH-1:0] ready_i,
  input  logic [XLEN-1:0]         value_i [2**ROB_WIDTH],
  input  logic                    wb_valid_1_i,
  input  logic [ROB_WIDTH-1:0]    wb_tag_1_i,
  input  logic [XLEN-1:0]         wb_value_1_i,
  input  logic                    wb_valid_2_i,
  input  logic [ROB_WIDTH-1:0]    wb_tag_2_i,
  input  logic [XLEN-1:0]         wb_value_2_i,
  output logic                    query_ready_o,
  output logic [XLEN-1:0]         query_value_o
);
  logic hit_busy_s;

  assign hit_busy_s = busy_i[query_tag_i];

`ifdef ROB_WB_FORWARD_EN
  logic fwd_1_s;
  logic fwd_2_s;

  assign fwd_1_s = hit_busy_s & wb_valid_1_i & (wb_tag_1_i == query_tag_i);
  assign fwd_2_s = hit_busy_s & wb_valid_2_i & (wb_tag_2_i == query_tag_i);

  // Port 1 forwarding takes priority over port 2, then stored state.
  always_comb begin
    query_ready_o = hit_busy_s & ready_i[query_tag_i];
    query_value_o = value_i[query_tag_i];
    if (fwd_1_s) begin
      query_ready_o = 1'b1;
      query_value_o = wb_value_1_i;
    end else if (fwd_2_s) begin
      query_ready_o = 1'b1;
      query_value_o = wb_value_2_i;
    end else begin
      query_ready_o = hit_busy_s & ready_i[query_tag_i];
    end
  end
`else
  logic unused_wb_s;

  assign unused_wb_s   = ^{wb_valid_1_i, wb_tag_1_i, wb_value_1_i,
                           wb_valid_2_i, wb_tag_2_i, wb_value_2_i};
  assign query_ready_o = hit_busy_s & ready_i[query_tag_i];
  assign query_value_o = value_i[query_tag_i];
`endif
endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: two writeback ports, two operand queries, one commit per cycle.
// Optional macro ROB_WB_FORWARD_EN enables same-cycle writeback forwarding to queries.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_WIDTH = ROB_WIDTH_DEF,
  parameter int XLEN      = XLEN_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 issue,
  input  logic [REG_WIDTH-1:0] issue_rd,
  output logic [ROB_WIDTH-1:0] issue_tag,
  output logic                 full,
  output logic                 empty,
  input  logic                 wb_valid_1,
  input  logic                 wb_valid_2,
  input  logic [ROB_WIDTH-1:0] wb_tag_1,
  input  logic [ROB_WIDTH-1:0] wb_tag_2,
  input  logic [XLEN-1:0]      wb_value_1,
  input  logic [XLEN-1:0]      wb_value_2,
  input  logic [ROB_WIDTH-1:0] query_tag_1,
  input  logic [ROB_WIDTH-1:0] query_tag_2,
  output logic                 query_ready_1,
  output logic                 query_ready_2,
  output logic [XLEN-1:0]      query_value_1,
  output logic [XLEN-1:0]      query_value_2,
  output logic                 commit,
  output logic [ROB_WIDTH-1:0] commit_tag,
  output logic [XLEN-1:0]      commit_value,
  output logic [REG_WIDTH-1:0] commit_rd
);
  localparam int ROB_SIZE = 2**ROB_WIDTH;

  logic [ROB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_WIDTH:0]   count_q, count_d;
  logic [ROB_SIZE-1:0]  busy_q, busy_d, ready_q, ready_d;
  logic [XLEN-1:0]      value_q [ROB_SIZE];
  logic [XLEN-1:0]      value_d [ROB_SIZE];
  logic [REG_WIDTH-1:0] rd_q [ROB_SIZE];
  logic [REG_WIDTH-1:0] rd_d [ROB_SIZE];
  logic                 commit_q, commit_d;
  logic [ROB_WIDTH-1:0] commit_tag_q, commit_tag_d;
  logic [XLEN-1:0]      commit_value_q, commit_value_d;
  logic [REG_WIDTH-1:0] commit_rd_q, commit_rd_d;
  logic                 do_issue_s, do_retire_s;

  assign issue_tag    = tail_q;
  assign full         = (count_q == (ROB_WIDTH+1)'(ROB_SIZE));
  assign empty        = (count_q == '0);
  assign do_issue_s   = rdy_in & issue & ~full;
  assign do_retire_s  = rdy_in & busy_q[head_q] & ready_q[head_q];
  assign commit       = commit_q;
  assign commit_tag   = commit_tag_q;
  assign commit_value = commit_value_q;
  assign commit_rd    = commit_rd_q;

  // Next state: writeback (port 1 last so it wins), then retire, then issue so a reissue wins.
  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    busy_d         = busy_q;
    ready_d        = ready_q;
    value_d        = value_q;
    rd_d           = rd_q;
    commit_d       = 1'b0;
    commit_tag_d   = commit_tag_q;
    commit_value_d = commit_value_q;
    commit_rd_d    = commit_rd_q;
    if (rdy_in && wb_valid_2 && busy_q[wb_tag_2]) begin
      ready_d[wb_tag_2] = 1'b1;
      value_d[wb_tag_2] = wb_value_2;
    end else begin
      ready_d = ready_d;
    end
    if (rdy_in && wb_valid_1 && busy_q[wb_tag_1]) begin
      ready_d[wb_tag_1] = 1'b1;
      value_d[wb_tag_1] = wb_value_1;
    end else begin
      ready_d = ready_d;
    end
    if (do_retire_s) begin
      busy_d[head_q] = 1'b0;
      head_d         = head_q + 1'b1;
      commit_d       = 1'b1;
      commit_tag_d   = head_q;
      commit_value_d = value_q[head_q];
      commit_rd_d    = rd_q[head_q];
    end else begin
      commit_d = 1'b0;
    end
    if (do_issue_s) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = 1'b0;
      rd_d[tail_q]    = issue_rd;
      tail_d          = tail_q + 1'b1;
    end else begin
      tail_d = tail_q;
    end
    case ({do_issue_s, do_retire_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards every in-flight entry and the pending commit.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      busy_q         <= '0;
      ready_q        <= '0;
      commit_q       <= 1'b0;
      commit_tag_q   <= '0;
      commit_value_q <= '0;
      commit_rd_q    <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      value_q        <= value_d;
      rd_q           <= rd_d;
      commit_q       <= commit_d;
      commit_tag_q   <= commit_tag_d;
      commit_value_q <= commit_value_d;
      commit_rd_q    <= commit_rd_d;
    end
  end

  rob_query_port #(.ROB_WIDTH(ROB_WIDTH), .XLEN(XLEN)) u_query_1 (
    .query_tag_i  (query_tag_1),
    .busy_i       (busy_q),
    .ready_i      (ready_q),
    .value_i      (value_q),
    .wb_valid_1_i (wb_valid_1),
    .wb_tag_1_i   (wb_tag_1),
    .wb_value_1_i (wb_value_1),
    .wb_valid_2_i (wb_valid_2),
    .wb_tag_2_i   (wb_tag_2),
    .wb_value_2_i (wb_value_2),
    .query_ready_o(query_ready_1),
    .query_value_o(query_value_1)
  );

  rob_query_port #(.ROB_WIDTH(ROB_WIDTH), .XLEN(XLEN)) u_query_2 (
    .query_tag_i  (query_tag_2),
    .busy_i       (busy_q),
    .ready_i      (ready_q),
    .value_i      (value_q),
    .wb_valid_1_i (wb_valid_1),
    .wb_tag_1_i   (wb_tag_1),
    .wb_value_1_i (wb_value_1),
    .wb_valid_2_i (wb_valid_2),
    .wb_tag_2_i   (wb_tag_2),
    .wb_value_2_i (wb_value_2),
    .query_ready_o(query_ready_2),
    .query_value_o(query_value_2)
  );
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic against an in-order queue model.
`timescale 1ns/1ps
module tb_reorder_buffer;
  localparam int SZ = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy, issue;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_tag;
  logic        full, empty;
  logic        wbv1, wbv2;
  logic [3:0]  wbt1, wbt2, qt1, qt2;
  logic [31:0] wbd1, wbd2;
  logic        qr1, qr2;
  logic [31:0] qv1, qv2;
  logic        commit;
  logic [3:0]  ctag;
  logic [31:0] cval;
  logic [4:0]  crd;

  reorder_buffer dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .issue(issue), .issue_rd(issue_rd), .issue_tag(issue_tag), .full(full), .empty(empty),
    .wb_valid_1(wbv1), .wb_valid_2(wbv2), .wb_tag_1(wbt1), .wb_tag_2(wbt2),
    .wb_value_1(wbd1), .wb_value_2(wbd2),
    .query_tag_1(qt1), .query_tag_2(qt2), .query_ready_1(qr1), .query_ready_2(qr2),
    .query_value_1(qv1), .query_value_2(qv2),
    .commit(commit), .commit_tag(ctag), .commit_value(cval), .commit_rd(crd)
  );

  typedef struct {
    int          tag;
    int          rd;
    bit          done;
    logic [31:0] val;
  } ent_t;

  ent_t        q[$];
  int          m_tail;
  bit          e_commit;
  int          e_ctag, e_crd;
  logic [31:0] e_cval;
  int          vectors = 0;
  int          errors  = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find(input int t);
    foreach (q[i]) if (q[i].tag == t) return i;
    return -1;
  endfunction

  task automatic model_query(input int t, output bit r, output logic [31:0] v);
    int i;
    i = find(t);
    r = 1'b0;
    v = '0;
    if (i >= 0 && q[i].done) begin r = 1'b1; v = q[i].val; end
`ifdef ROB_WB_FORWARD_EN
    if (i >= 0) begin
      if (wbv1 && int'(wbt1) == t) begin r = 1'b1; v = wbd1; end
      else if (wbv2 && int'(wbt2) == t) begin r = 1'b1; v = wbd2; end
    end
`endif
  endtask

  task automatic check_outputs();
    bit r;
    logic [31:0] v;
    cmp("issue_tag", issue_tag, m_tail);
    cmp("full", full, q.size() == SZ);
    cmp("empty", empty, q.size() == 0);
    model_query(qt1, r, v);
    cmp("query_ready_1", qr1, r);
    if (r) cmp("query_value_1", qv1, v);
    model_query(qt2, r, v);
    cmp("query_ready_2", qr2, r);
    if (r) cmp("query_value_2", qv2, v);
    cmp("commit", commit, e_commit);
    if (e_commit) begin
      cmp("commit_tag", ctag, e_ctag);
      cmp("commit_value", cval, e_cval);
      cmp("commit_rd", crd, e_crd);
    end
  endtask

  task automatic model_edge();
    bit   ret, was_full;
    int   i;
    ent_t e;
    if (rst) begin
      q.delete();
      m_tail = 0; e_commit = 0; e_ctag = 0; e_cval = '0; e_crd = 0;
      return;
    end
    e_commit = 0;
    if (!rdy) return;
    was_full = (q.size() == SZ);
    ret = (q.size() > 0) && q[0].done;
    if (ret) begin
      e_commit = 1; e_ctag = q[0].tag; e_cval = q[0].val; e_crd = q[0].rd;
    end
    if (wbv2) begin i = find(wbt2); if (i >= 0) begin q[i].done = 1; q[i].val = wbd2; end end
    if (wbv1) begin i = find(wbt1); if (i >= 0) begin q[i].done = 1; q[i].val = wbd1; end end
    if (ret) void'(q.pop_front());
    if (issue && !was_full) begin
      e.tag = m_tail; e.rd = issue_rd; e.done = 0; e.val = '0;
      q.push_back(e);
      m_tail = (m_tail + 1) % SZ;
    end
  endtask

  task automatic cycle();
    #2;
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; rdy = 1; issue = 0; issue_rd = 0;
    wbv1 = 0; wbv2 = 0; wbt1 = 0; wbt2 = 0; wbd1 = 0; wbd2 = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cycle();
    rst = 0;
    cmp("rst_commit", commit, 1'b0);
    cmp("rst_commit_tag", ctag, 4'd0);
    cmp("rst_commit_value", cval, 32'd0);
    cmp("rst_commit_rd", crd, 5'd0);
    cmp("rst_empty", empty, 1'b1);
    cmp("rst_issue_tag", issue_tag, 4'd0);
  endtask

  task automatic issue_one(input int rd);
    idle(); issue = 1; issue_rd = 5'(rd); cycle(); idle();
  endtask

  initial begin
    idle();
    qt1 = 0; qt2 = 0;
    rst = 1;
    @(posedge clk); #1;
    model_edge();
    do_reset();

    // single issue / writeback / commit
    cmp("lit_first_tag", issue_tag, 4'd0);
    issue_one(3);
    wbv1 = 1; wbt1 = 0; wbd1 = 32'h55; cycle(); idle();
    cycle();
    cmp("lit_commit", commit, 1'b1);
    cmp("lit_commit_tag", ctag, 4'd0);
    cmp("lit_commit_value", cval, 32'h55);
    cmp("lit_commit_rd", crd, 5'd3);
    cycle();

    // fill, overflow, drain and wrap
    do_reset();
    for (int i = 0; i < SZ; i++) issue_one(i);
    cmp("lit_full", full, 1'b1);
    issue = 1; issue_rd = 5'd31; cycle(); idle();
    cmp("lit_full_held", full, 1'b1);
    cmp("lit_tail_held", issue_tag, 4'd0);
    for (int i = 0; i < SZ; i++) begin
      wbv1 = 1; wbt1 = 4'(i); wbd1 = 32'(100 + i); cycle();
    end
    idle();
    cycle();
    cmp("lit_last_commit_tag", ctag, 4'd15);
    cmp("lit_last_commit_value", cval, 32'd115);
    cycle();
    cmp("lit_drained_empty", empty, 1'b1);
    cmp("lit_tail_wrap", issue_tag, 4'd0);

    // out-of-order writeback, in-order commit
    do_reset();
    issue_one(7); issue_one(8);
    wbv1 = 1; wbt1 = 4'd1; wbd1 = 32'h11; cycle(); idle();
    wbv1 = 1; wbt1 = 4'd0; wbd1 = 32'h22; cycle(); idle();
    cmp("lit_ooo_none", commit, 1'b0);
    cycle();
    cmp("lit_ooo_tag0", ctag, 4'd0);
    cmp("lit_ooo_val0", cval, 32'h22);
    cycle();
    cmp("lit_ooo_tag1", ctag, 4'd1);
    cmp("lit_ooo_val1", cval, 32'h11);

    // same tag on both ports: port 1 wins
    do_reset();
    issue_one(1); issue_one(2); issue_one(3);
    wbv1 = 1; wbt1 = 4'd0; wbd1 = 32'h1; wbv2 = 1; wbt2 = 4'd1; wbd2 = 32'h2; cycle(); idle();
    wbv1 = 1; wbt1 = 4'd2; wbd1 = 32'hA; wbv2 = 1; wbt2 = 4'd2; wbd2 = 32'hB; cycle(); idle();
    cycle(); cycle();
    cmp("lit_dual_tag", ctag, 4'd2);
    cmp("lit_dual_value", cval, 32'hA);

    // stall freezes everything
    do_reset();
    issue_one(4);
    wbv1 = 1; wbt1 = 4'd0; wbd1 = 32'h31; cycle(); idle();
    for (int i = 0; i < 3; i++) begin
      rdy = 0; cycle();
      cmp("lit_stall_commit", commit, 1'b0);
      cmp("lit_stall_tail", issue_tag, 4'd1);
    end
    rdy = 1; cycle();
    cmp("lit_resume_commit", commit, 1'b1);
    cmp("lit_resume_value", cval, 32'h31);

    // same-cycle writeback visibility on a query
    do_reset();
    for (int i = 0; i < 5; i++) issue_one(i);
    qt1 = 4'd4; wbv2 = 1; wbt2 = 4'd4; wbd2 = 32'h7;
    #2;
`ifdef ROB_WB_FORWARD_EN
    cmp("lit_fwd_ready", qr1, 1'b1);
    cmp("lit_fwd_value", qv1, 32'h7);
`else
    cmp("lit_nofwd_ready", qr1, 1'b0);
`endif
    cycle(); idle();

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      rst  = ($urandom_range(299) == 0);
      rdy  = ($urandom_range(9) != 0);
      issue = $urandom_range(1);
      issue_rd = 5'($urandom);
      wbv1 = ($urandom_range(9) < 6);
      wbv2 = ($urandom_range(9) < 5);
      wbt1 = (q.size() > 0 && $urandom_range(9) < 8) ? 4'(q[$urandom_range(q.size() - 1)].tag) : 4'($urandom);
      wbt2 = ($urandom_range(3) == 0) ? wbt1 :
             ((q.size() > 0 && $urandom_range(9) < 8) ? 4'(q[$urandom_range(q.size() - 1)].tag) : 4'($urandom));
      wbd1 = $urandom; wbd2 = $urandom;
      qt1 = ($urandom_range(1) == 0) ? wbt1 : 4'($urandom);
      qt2 = ($urandom_range(1) == 0) ? wbt2 : 4'($urandom);
      cycle();
    end
    idle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
